// File: rtl/instruction_fetch.sv
// IF stage: program counter, loader-writable instruction memory and the
// IF/ID register feeding decode. Stops itself when a HALT word is latched.
module instruction_fetch #(
  parameter int NB_DATA   = 32,
  parameter int MEM_DEPTH = 64
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_pc_src,
  input  logic [NB_DATA-1:0] i_pc_target,
  input  logic               i_wr_en,
  input  logic [NB_DATA-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  output logic [NB_DATA-1:0] o_pc,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic               o_halt
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [NB_DATA-1:0] NOP  = '0;
  localparam logic [NB_DATA-1:0] HALT = '1;

  logic [NB_DATA-1:0] mem [MEM_DEPTH];
  logic [NB_DATA-1:0] pc, pc_plus4, fetch_word, instr, pc4;
  logic               halted, advance, is_halt, pc_in_range, wr_in_range;

  // Anything above the memory window reads as NOP and is never written.
  assign pc_in_range = (pc[NB_DATA-1:AW+2] == '0);
  assign wr_in_range = (i_wr_addr[NB_DATA-1:AW+2] == '0);
  assign fetch_word  = pc_in_range ? mem[pc[AW+1:2]] : NOP;
  assign is_halt     = (fetch_word == HALT);
  assign pc_plus4    = pc + NB_DATA'(4);
  assign advance     = i_enable & ~halted;

  // Loader port: runs regardless of enable, stall, halt or reset.
  always_ff @(posedge clk) begin
    if (i_wr_en && wr_in_range)
      mem[i_wr_addr[AW+1:2]] <= i_wr_data;
  end

  // Program counter: redirect beats stall; a HALT word parks the PC
  // unless it is being flushed away.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)
      pc <= '0;
    else if (advance) begin
      if (i_pc_src)
        pc <= {i_pc_target[NB_DATA-1:2], 2'b00};
      else if (i_stall)
        pc <= pc;
      else if (is_halt && !i_flush)
        pc <= pc;
      else
        pc <= pc_plus4;
    end
  end

  // IF/ID register: flush inserts a bubble even while stalled.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      instr <= NOP;
      pc4   <= '0;
    end else if (advance) begin
      if (i_flush) begin
        instr <= NOP;
        pc4   <= pc_plus4;
      end else if (!i_stall) begin
        instr <= fetch_word;
        pc4   <= pc_plus4;
      end
    end
  end

  // Sticky halt: set when a HALT word actually lands in IF/ID.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)
      halted <= 1'b0;
    else if (advance && !i_stall && !i_flush && is_halt)
      halted <= 1'b1;
  end

  assign o_pc          = pc;
  assign o_instruction = instr;
  assign o_pcounter4   = pc4;
  assign o_halt        = halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations
// followed by random traffic, all checked against a behavioural model.
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_enable = 1'b0, i_stall = 1'b0, i_flush = 1'b0, i_pc_src = 1'b0;
  logic [31:0] i_pc_target = '0;
  logic        i_wr_en = 1'b0;
  logic [31:0] i_wr_addr = '0, i_wr_data = '0;
  logic [31:0] o_pc, o_instruction, o_pcounter4;
  logic        o_halt;

  int total = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  instruction_fetch #(.NB_DATA(32), .MEM_DEPTH(64)) dut (
    .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_stall(i_stall),
    .i_flush(i_flush), .i_pc_src(i_pc_src), .i_pc_target(i_pc_target),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_pc(o_pc), .o_instruction(o_instruction), .o_pcounter4(o_pcounter4),
    .o_halt(o_halt)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the stage must hold after each edge.
  logic [31:0] m_mem [64];
  logic [31:0] m_pc = '0, m_instr = '0, m_pc4 = '0;
  logic        m_halted = 1'b0;

  always @(posedge clk) begin
    logic [31:0] fw;
    fw = (m_pc < 32'd256) ? m_mem[m_pc / 4] : 32'h0;
    if (i_rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_halted = 0;
    end else if (i_enable && !m_halted) begin
      logic [31:0] old_pc;
      old_pc = m_pc;
      if (i_pc_src)                       m_pc = i_pc_target & 32'hFFFF_FFFC;
      else if (i_stall)                   m_pc = old_pc;
      else if (fw == HALT && !i_flush)    m_pc = old_pc;
      else                                m_pc = old_pc + 4;
      if (i_flush) begin
        m_instr = 0; m_pc4 = old_pc + 4;
      end else if (!i_stall) begin
        m_instr = fw; m_pc4 = old_pc + 4;
        if (fw == HALT) m_halted = 1;
      end
    end
    if (i_wr_en && i_wr_addr < 32'd256) m_mem[i_wr_addr / 4] = i_wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", o_pc, m_pc);
      check("model_instr", o_instruction, m_instr);
      check("model_pc4", o_pcounter4, m_pc4);
      check("model_halt", {31'b0, o_halt}, {31'b0, m_halted});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    i_rst = 1'b1;
    #1;
    check("rst_pc", o_pc, 32'h0);
    check("rst_instr", o_instruction, 32'h0);
    check("rst_pc4", o_pcounter4, 32'h0);
    check("rst_halt", {31'b0, o_halt}, 32'h0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = data;
    step();
    i_wr_en = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] p4, input logic h);
    check({tag, "_pc"}, o_pc, pc);
    check({tag, "_instr"}, o_instruction, ins);
    check({tag, "_pc4"}, o_pcounter4, p4);
    check({tag, "_halt"}, {31'b0, o_halt}, {31'b0, h});
  endtask

  initial begin
    logic [31:0] prog [64];
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0007;
    prog[2] = 32'h0022_1820; prog[3] = HALT;
    prog[4] = 32'h2222_2222; prog[8] = 32'h1111_1111;

    #1;
    do_reset();
    for (int i = 0; i < 64; i++) wr(i * 4, prog[i]);

    // Program runs to HALT and parks.
    i_enable = 1'b1;
    step(); expect_out("run1", 32'd4,  32'h2001_0005, 32'd4,  1'b0);
    step(); expect_out("run2", 32'd8,  32'h2002_0007, 32'd8,  1'b0);
    step(); expect_out("run3", 32'd12, 32'h0022_1820, 32'd12, 1'b0);
    step(); expect_out("run4", 32'd12, HALT,          32'd16, 1'b1);
    step(); expect_out("run5", 32'd12, HALT,          32'd16, 1'b1);

    // Mid-run reset keeps memory; then stall holds at PC 8.
    do_reset();
    step(); check("refetch", o_instruction, 32'h2001_0005);
    step();
    i_stall = 1'b1;
    step(); expect_out("stall1", 32'd8, 32'h2002_0007, 32'd8, 1'b0);
    step(); expect_out("stall2", 32'd8, 32'h2002_0007, 32'd8, 1'b0);
    i_stall = 1'b0;
    step(); expect_out("unstall", 32'd12, 32'h0022_1820, 32'd12, 1'b0);

    // Redirect with flush from PC 8.
    do_reset();
    step(); step();
    i_pc_src = 1'b1; i_pc_target = 32'h21; i_flush = 1'b1;
    step(); expect_out("redir", 32'h20, 32'h0, 32'd12, 1'b0);
    i_pc_src = 1'b0; i_flush = 1'b0;
    step(); expect_out("target", 32'h24, 32'h1111_1111, 32'h24, 1'b0);

    // Flushed HALT does not halt.
    i_enable = 1'b0;
    do_reset();
    wr(32'd4, HALT);
    i_enable = 1'b1;
    step();
    i_flush = 1'b1; i_pc_src = 1'b1; i_pc_target = 32'h10;
    step(); expect_out("flushhalt", 32'h10, 32'h0, 32'd8, 1'b0);
    i_flush = 1'b0; i_pc_src = 1'b0;
    step(); expect_out("afterflush", 32'h14, 32'h2222_2222, 32'h14, 1'b0);
    i_enable = 1'b0;
    wr(32'd4, 32'h2002_0007);

    // Enable toggling and same-cycle loader write at the fetch address.
    do_reset();
    i_enable = 1'b1; step(); check("tog_pc1", o_pc, 32'd4);
    i_enable = 1'b0; step(); check("tog_pc2", o_pc, 32'd4);
    i_enable = 1'b1;
    i_wr_en = 1'b1; i_wr_addr = 32'd4; i_wr_data = 32'h3333_3333;
    step(); i_wr_en = 1'b0;
    check("wr_old", o_instruction, 32'h2002_0007);
    check("tog_pc3", o_pc, 32'd8);
    i_enable = 1'b0; step(); check("tog_pc4", o_pc, 32'd8);
    i_enable = 1'b1; i_pc_src = 1'b1; i_pc_target = 32'd4;
    step(); i_pc_src = 1'b0;
    step(); check("wr_new", o_instruction, 32'h3333_3333);
    i_enable = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 64; i++)
      wr(i * 4, ($urandom_range(0, 7) == 0) ? HALT : $urandom);
    for (int n = 0; n < 3000; n++) begin
      if ((m_halted && $urandom_range(0, 4) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        i_enable    = ($urandom_range(0, 9) < 8);
        i_stall     = ($urandom_range(0, 99) < 15);
        i_flush     = ($urandom_range(0, 9) == 0);
        i_pc_src    = ($urandom_range(0, 9) == 0);
        i_pc_target = $urandom_range(0, 32'h13F);
        i_wr_en     = ($urandom_range(0, 9) == 0);
        i_wr_addr   = $urandom_range(0, 32'h12F);
        i_wr_data   = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
        step();
      end
    end
    i_wr_en = 1'b0; i_enable = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
